// File: rtl/poker_pkg.sv
// rtl/poker_pkg.sv - Shared states, card limits, winner codes and LFSR helpers for poker_dealer
package poker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_BET_PRE,
    ST_BET_FLOP,
    ST_BET_TURN,
    ST_BET_RIVER,
    ST_HANDOFF,
    ST_DONE
  } state_t;

  localparam logic [3:0] RANK_MIN   = 4'd1;
  localparam logic [3:0] RANK_MAX   = 4'd13;
  localparam logic [2:0] MAX_COPIES = 3'd4;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of the shift register)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic state_t next_round(input state_t s);
    case (s)
      ST_BET_PRE:  return ST_BET_FLOP;
      ST_BET_FLOP: return ST_BET_TURN;
      default:     return ST_BET_RIVER;
    endcase
  endfunction

endpackage

// File: rtl/poker_deck.sv
// rtl/poker_deck.sv - Free-running LFSR card source with per-rank use counters
module poker_deck
  import poker_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       draw,
  output logic [3:0] rank,
  output logic       valid
);

  logic [7:0] lfsr_q;
  logic [2:0] count_q [0:12];
  logic       in_range;
  logic [3:0] idx;
  logic [2:0] cur_count;

  assign rank     = lfsr_q[3:0];
  assign in_range = (rank >= RANK_MIN) && (rank <= RANK_MAX);
  assign idx      = rank - 4'd1;

  // Look up how many copies of the candidate rank are already out
  always_comb begin
    cur_count = '0;
    if (in_range) cur_count = count_q[idx];
  end

  assign valid = draw && in_range && (cur_count < MAX_COPIES);

  // LFSR steps every cycle; counters clear on a new hand and count accepted draws
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
      for (int i = 0; i < 13; i++) count_q[i] <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      if (clear) begin
        for (int i = 0; i < 13; i++) count_q[i] <= '0;
      end else if (valid) begin
        count_q[idx] <= cur_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/poker_dealer.sv
// rtl/poker_dealer.sv - Poker game core: deal, betting rounds, reveal, showdown; POKER_HANDOFF_EN adds seat-swap screen
module poker_dealer
  import poker_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       SCEN,
  input  logic       Check,
  input  logic       Bet,
  input  logic       Call,
  input  logic       Fold,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3,
  output logic [3:0] card4,
  output logic [3:0] card5,
  output logic [3:0] player1card1,
  output logic [3:0] player1card2,
  output logic [3:0] player2card1,
  output logic [3:0] player2card2,
  output logic       playerTurn,
  output logic       dispCards,
  output logic       Done,
  output logic [1:0] winner
);

  state_t     state_q, state_d;
  logic       turn_q, turn_d;
  logic       bet_q, bet_d;
  logic       checked_q, checked_d;
  logic [1:0] reveal_q, reveal_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] deal_idx_q;
  logic [3:0] cards_q [0:8];
  logic       clear_deck;
  logic       round_end;
  logic       deal_draw;
  logic [3:0] deck_rank;
  logic       deck_valid;
  logic [4:0] sum_p1, sum_p2;
  logic [1:0] showdown;
  logic       idle_st, done_st;
`ifdef POKER_HANDOFF_EN
  state_t     saved_q, saved_d;
`endif

  assign deal_draw = (state_q == ST_DEAL);

  poker_deck #(.SEED(SEED)) u_deck (
    .clk   (Clk),
    .reset (Reset),
    .clear (clear_deck),
    .draw  (deal_draw),
    .rank  (deck_rank),
    .valid (deck_valid)
  );

  // Card slot order: 0 P1c1, 1 P2c1, 2 P1c2, 3 P2c2, 4..8 community
  assign sum_p1   = {1'b0, cards_q[0]} + {1'b0, cards_q[2]};
  assign sum_p2   = {1'b0, cards_q[1]} + {1'b0, cards_q[3]};
  assign showdown = (sum_p1 > sum_p2) ? WIN_P1 : (sum_p2 > sum_p1) ? WIN_P2 : WIN_TIE;

  // Next-state, turn, bet and reveal decisions
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    bet_d      = bet_q;
    checked_d  = checked_q;
    reveal_d   = reveal_q;
    winner_d   = winner_q;
    clear_deck = 1'b0;
    round_end  = 1'b0;
`ifdef POKER_HANDOFF_EN
    saved_d    = saved_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          clear_deck = 1'b1;
          state_d    = ST_DEAL;
          turn_d     = 1'b0;
          bet_d      = 1'b0;
          checked_d  = 1'b0;
          reveal_d   = 2'd0;
          winner_d   = WIN_NONE;
        end
      end
      ST_DEAL: begin
        if (deck_valid && deal_idx_q == 4'd8) begin
          state_d = ST_BET_PRE;
          turn_d  = 1'b0;
        end
      end
      ST_BET_PRE, ST_BET_FLOP, ST_BET_TURN, ST_BET_RIVER: begin
        // Only the highest-priority asserted action is considered; if illegal it is dropped
        if (SCEN) begin
          if (Fold) begin
            state_d  = ST_DONE;
            winner_d = turn_q ? WIN_P1 : WIN_P2;
          end else if (Call) begin
            round_end = bet_q;
          end else if (Bet) begin
            if (!bet_q) begin
              bet_d  = 1'b1;
              turn_d = ~turn_q;
            end
          end else if (Check) begin
            if (!bet_q) begin
              if (checked_q) begin
                round_end = 1'b1;
              end else begin
                checked_d = 1'b1;
                turn_d    = ~turn_q;
              end
            end
          end
        end
        if (round_end) begin
          if (state_q == ST_BET_RIVER) begin
            state_d  = ST_DONE;
            winner_d = showdown;
          end else begin
            state_d   = next_round(state_q);
            reveal_d  = reveal_q + 2'd1;
            turn_d    = 1'b0;
            bet_d     = 1'b0;
            checked_d = 1'b0;
          end
        end
`ifdef POKER_HANDOFF_EN
        if (turn_d != turn_q && state_d != ST_DONE) begin
          saved_d = state_d;
          state_d = ST_HANDOFF;
        end
`endif
      end
`ifdef POKER_HANDOFF_EN
      ST_HANDOFF: begin
        if (Ack) state_d = saved_q;
      end
`endif
      ST_DONE: begin
        if (Ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and betting registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      turn_q    <= 1'b0;
      bet_q     <= 1'b0;
      checked_q <= 1'b0;
      reveal_q  <= 2'd0;
      winner_q  <= WIN_NONE;
`ifdef POKER_HANDOFF_EN
      saved_q   <= ST_IDLE;
`endif
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      bet_q     <= bet_d;
      checked_q <= checked_d;
      reveal_q  <= reveal_d;
      winner_q  <= winner_d;
`ifdef POKER_HANDOFF_EN
      saved_q   <= saved_d;
`endif
    end
  end

  // Store each accepted card into the next slot of the dealing order
  always_ff @(posedge Clk) begin
    if (Reset || clear_deck) begin
      deal_idx_q <= 4'd0;
      for (int i = 0; i < 9; i++) cards_q[i] <= '0;
    end else if (deal_draw && deck_valid) begin
      cards_q[deal_idx_q] <= deck_rank;
      deal_idx_q          <= deal_idx_q + 4'd1;
    end
  end

  assign idle_st = (state_q == ST_IDLE);
  assign done_st = (state_q == ST_DONE);

  assign player1card1 = idle_st ? 4'd0 : cards_q[0];
  assign player2card1 = idle_st ? 4'd0 : cards_q[1];
  assign player1card2 = idle_st ? 4'd0 : cards_q[2];
  assign player2card2 = idle_st ? 4'd0 : cards_q[3];

  assign card1 = (!idle_st && (done_st || reveal_q >= 2'd1)) ? cards_q[4] : 4'd0;
  assign card2 = (!idle_st && (done_st || reveal_q >= 2'd1)) ? cards_q[5] : 4'd0;
  assign card3 = (!idle_st && (done_st || reveal_q >= 2'd1)) ? cards_q[6] : 4'd0;
  assign card4 = (!idle_st && (done_st || reveal_q >= 2'd2)) ? cards_q[7] : 4'd0;
  assign card5 = (!idle_st && (done_st || reveal_q == 2'd3)) ? cards_q[8] : 4'd0;

  assign playerTurn = turn_q;
  assign dispCards  = (state_q == ST_IDLE) || (state_q == ST_DEAL) || (state_q == ST_HANDOFF);
  assign Done       = done_st;
  assign winner     = done_st ? winner_q : WIN_NONE;

endmodule

// File: tb/tb_poker_dealer.sv
// tb/tb_poker_dealer.sv - Randomized and directed checks of poker_dealer against a game-level reference model
module tb_poker_dealer;

  localparam logic [7:0] TB_SEED = 8'h01;
  localparam int P_IDLE = 0;
  localparam int P_DEAL = 1;
  localparam int P_BET  = 2;
  localparam int P_DONE = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1, Start = 1'b0, Ack = 1'b0, SCEN = 1'b0;
  logic Check = 1'b0, Bet = 1'b0, Call = 1'b0, Fold = 1'b0;
  logic [3:0] card1, card2, card3, card4, card5;
  logic [3:0] player1card1, player1card2, player2card1, player2card2;
  logic       playerTurn, dispCards, Done;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  poker_dealer #(.SEED(TB_SEED)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .SCEN(SCEN),
    .Check(Check), .Bet(Bet), .Call(Call), .Fold(Fold),
    .card1(card1), .card2(card2), .card3(card3), .card4(card4), .card5(card5),
    .player1card1(player1card1), .player1card2(player1card2),
    .player2card1(player2card1), .player2card2(player2card2),
    .playerTurn(playerTurn), .dispCards(dispCards), .Done(Done), .winner(winner)
  );

  always #5 Clk = ~Clk;

  // Reference model: game phase, round number, dealt cards in dealing order
  int         m_phase, m_round, m_turn, m_bet, m_checks, m_winner, m_ndealt;
  int         m_used [14];
  int         m_dealt [9];
  logic [7:0] m_lfsr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int shown_cards(input int round);
    case (round)
      0: return 0;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int exp_comm(input int k);
    if (m_phase == P_DONE) return m_dealt[3 + k];
    if (m_phase == P_BET && shown_cards(m_round) >= k) return m_dealt[3 + k];
    return 0;
  endfunction

  function automatic int exp_hole(input int i);
    if (m_phase == P_IDLE) return 0;
    return m_dealt[i];
  endfunction

  always @(posedge Clk) begin : ref_model
    int  cand;
    int  s1, s2;
    bit  fin;
    if (Reset) begin
      m_phase = P_IDLE; m_round = 0; m_turn = 0; m_bet = 0; m_checks = 0;
      m_winner = 0; m_ndealt = 0;
      foreach (m_used[i]) m_used[i] = 0;
      foreach (m_dealt[i]) m_dealt[i] = 0;
      m_lfsr = TB_SEED;
    end else begin
      fin = 0;
      case (m_phase)
        P_IDLE: if (Start) begin
          m_phase = P_DEAL; m_ndealt = 0; m_round = 0; m_turn = 0; m_bet = 0; m_checks = 0;
          foreach (m_used[i]) m_used[i] = 0;
          foreach (m_dealt[i]) m_dealt[i] = 0;
        end
        P_DEAL: begin
          cand = int'(m_lfsr) % 16;
          if (cand >= 1 && cand <= 13 && m_used[cand] < 4) begin
            m_used[cand] = m_used[cand] + 1;
            m_dealt[m_ndealt] = cand;
            m_ndealt = m_ndealt + 1;
            if (m_ndealt == 9) m_phase = P_BET;
          end
        end
        P_BET: if (SCEN) begin
          if (Fold) begin
            m_phase = P_DONE;
            m_winner = (m_turn == 0) ? 2 : 1;
          end else if (Call) begin
            if (m_bet != 0) fin = 1;
          end else if (Bet) begin
            if (m_bet == 0) begin m_bet = 1; m_turn = 1 - m_turn; end
          end else if (Check) begin
            if (m_bet == 0) begin
              m_checks = m_checks + 1;
              if (m_checks == 2) fin = 1;
              else m_turn = 1 - m_turn;
            end
          end
          if (fin) begin
            if (m_round == 3) begin
              s1 = m_dealt[0] + m_dealt[2];
              s2 = m_dealt[1] + m_dealt[3];
              m_phase = P_DONE;
              m_winner = (s1 > s2) ? 1 : (s2 > s1) ? 2 : 3;
            end else begin
              m_round = m_round + 1; m_turn = 0; m_bet = 0; m_checks = 0;
            end
          end
        end
        default: if (Ack) m_phase = P_IDLE;
      endcase
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("card1", card1, exp_comm(1));
      chk("card2", card2, exp_comm(2));
      chk("card3", card3, exp_comm(3));
      chk("card4", card4, exp_comm(4));
      chk("card5", card5, exp_comm(5));
      chk("p1c1", player1card1, exp_hole(0));
      chk("p2c1", player2card1, exp_hole(1));
      chk("p1c2", player1card2, exp_hole(2));
      chk("p2c2", player2card2, exp_hole(3));
      chk("playerTurn", playerTurn, m_turn);
      chk("dispCards", dispCards, (m_phase <= P_DEAL) ? 1 : 0);
      chk("Done", Done, (m_phase == P_DONE) ? 1 : 0);
      chk("winner", winner, (m_phase == P_DONE) ? m_winner : 0);
    end
  end

  task automatic act(input bit f, input bit c, input bit b, input bit k);
    @(negedge Clk);
    SCEN = 1'b1; Fold = f; Call = c; Bet = b; Check = k;
    @(negedge Clk);
    SCEN = 1'b0; Fold = 1'b0; Call = 1'b0; Bet = 1'b0; Check = 1'b0;
  endtask

  task automatic start_hand();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_deal();
    bit got;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge Clk);
      if (!dispCards) got = 1;
    end
    chk("deal_within_bound", got, 1);
    chk("hole_p1c1_range", (player1card1 >= 1 && player1card1 <= 13), 1);
    chk("hole_p2c2_range", (player2card2 >= 1 && player2card2 <= 13), 1);
    chk("pre_card1_hidden", card1, 0);
    chk("pre_card5_hidden", card5, 0);
  endtask

  task automatic ack_done();
    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    cmp_en = 1;
    @(negedge Clk);
    chk("rst_card1", card1, 0);
    chk("rst_p1c1", player1card1, 0);
    chk("rst_Done", Done, 0);
    chk("rst_winner", winner, 0);
    chk("rst_dispCards", dispCards, 1);
    chk("rst_playerTurn", playerTurn, 0);

    // Hand started on the first cycle after reset: deal is fully determined by SEED=01
    Reset = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_deal();
    chk("lit_p1c1", player1card1, 2);
    chk("lit_p2c1", player2card1, 4);
    chk("lit_p1c2", player1card2, 8);
    chk("lit_p2c2", player2card2, 1);
    act(0, 0, 0, 1);
    chk("first_check_turn", playerTurn, 1);
    act(0, 0, 0, 1);
    chk("flop_card1", card1, 3);
    chk("flop_card2", card2, 7);
    chk("flop_card3", card3, 12);
    chk("flop_card4_hidden", card4, 0);
    chk("flop_turn", playerTurn, 0);
    act(0, 0, 1, 0);
    act(0, 1, 0, 0);
    chk("turn_card4", card4, 8);
    chk("turn_card5_hidden", card5, 0);
    act(0, 1, 0, 0);
    chk("call_no_bet_ignored", playerTurn, 0);
    act(0, 0, 1, 0);
    chk("bet_turn", playerTurn, 1);
    act(0, 0, 1, 0);
    chk("bet_after_bet_ignored", playerTurn, 1);
    chk("bet_after_bet_card5", card5, 0);
    act(0, 1, 0, 0);
    chk("river_card5", card5, 1);
    act(0, 0, 0, 1);
    act(0, 0, 0, 1);
    chk("showdown_done", Done, 1);
    chk("showdown_winner", winner, 1);
    ack_done();

    // Fold with simultaneous check by P2 in the flop round
    start_hand();
    wait_deal();
    act(0, 0, 0, 1);
    act(0, 0, 0, 1);
    chk("flop_c1_nz", (card1 != 0), 1);
    chk("flop_c3_nz", (card3 != 0), 1);
    act(0, 0, 0, 1);
    act(1, 0, 0, 1);
    chk("fold_done", Done, 1);
    chk("fold_winner", winner, 1);
    ack_done();
    chk("ack_idle_disp", dispCards, 1);

    // Reset in the middle of dealing
    start_hand();
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_disp", dispCards, 1);
    chk("mid_rst_p1c1", player1card1, 0);
    chk("mid_rst_done", Done, 0);
    start_hand();
    wait_deal();

    // Random play for the rest of the run
    for (int h = 0; h < 25; h++) begin
      bit got;
      got = 0;
      for (int n = 0; n < 3000 && !got; n++) begin
        @(negedge Clk);
        if (Done) begin
          got = 1;
        end else begin
          SCEN  = ($urandom_range(0, 2) == 0);
          Fold  = ($urandom_range(0, 15) == 0);
          Call  = $urandom_range(0, 1);
          Bet   = $urandom_range(0, 1);
          Check = $urandom_range(0, 1);
          Start = ($urandom_range(0, 7) == 0);
          Ack   = ($urandom_range(0, 7) == 0);
        end
      end
      SCEN = 0; Fold = 0; Call = 0; Bet = 0; Check = 0; Start = 0; Ack = 0;
      chk("hand_reaches_done", got, 1);
      if (!got) begin
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk); Reset = 1'b0;
        start_hand();
      end else if (h % 3 == 0) begin
        Start = 1'b1;
        repeat (3) @(negedge Clk);
        chk("start_held_in_done", Done, 1);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
      end else begin
        ack_done();
        if ($urandom_range(0, 3) == 0) begin
          start_hand();
          repeat ($urandom_range(1, 6)) @(negedge Clk);
          Reset = 1'b1;
          @(negedge Clk);
          Reset = 1'b0;
          chk("rand_rst_disp", dispCards, 1);
        end
        start_hand();
      end
      wait_deal();
    end

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
